mac_dot_ctrl: RTL
=================

MAC_DOT_CTRL -- requirements
Module: mac_dot_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the dot-product length field.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: begin a dot product; sampled only in IDLE.
REQ-005 SHALL have port len, input, LEN_W: number of operand pairs; latched on an accepted start.
REQ-006 SHALL have port in_valid, input, 1: operand pair present.
REQ-007 SHALL have port in_ready, output, 1: controller accepts the operand pair this cycle.
REQ-008 SHALL have port in_a, input, 16: unsigned operand A.
REQ-009 SHALL have port in_b, input, 16: unsigned operand B.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-012 SHALL have port out_result, output, 32: accumulated dot product.
REQ-013 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, CLEAR, ACCUM and DONE.
REQ-015 IDLE with start=1 SHALL latch len, then go to CLEAR; start in any other state SHALL be ignored.
REQ-016 CLEAR SHALL last exactly 1 cycle, drive the MAC reset high, and reset the beat counter; next state is ACCUM if the latched len>0, else DONE.
REQ-017 ACCUM SHALL drive in_ready=1; a beat transfers when in_valid&&in_ready, and in_a/in_b SHALL be passed combinationally to the MAC in that cycle.
REQ-018 In any cycle without a transfer, including every cycle outside ACCUM, MAC operands SHALL be driven to 0, so the accumulator holds its value.
REQ-019 After the transfer that brings the count to len, the next state SHALL be DONE; in_ready SHALL be 0 from that next cycle.
REQ-020 DONE SHALL drive out_valid=1 with out_result = MAC accumulator, stable until out_ready=1, then go to IDLE.
REQ-021 Latency: start to first in_ready=1 SHALL be 2 cycles; last accepted beat to out_valid=1 SHALL be 1 cycle.
REQ-022 Arithmetic SHALL be unsigned; each product is 32 bits and the accumulation wraps modulo 2^32.
REQ-023 len=0 SHALL produce out_valid with out_result=0 two cycles after start.

Reset
REQ-024 reset=1 SHALL force IDLE, counter=0 and the MAC reset, in any state.
REQ-025 On reset, outputs SHALL be: in_ready=0, out_valid=0, busy=0, out_result=0.
REQ-026 reset asserted mid-ACCUM or mid-DONE SHALL discard the partial result; no out_valid SHALL follow.

Configuration
REQ-027 Macro MAC_DOT_CTRL_OVF_EN defined SHALL add the output port ovf (1 bit); undefined, the port and its logic SHALL be absent.
REQ-028 ovf behaviour:
- Sticky flag, set when a transfer's 32-bit product plus the accumulator exceeds 2^32-1.
- Cleared in CLEAR and on reset.
- Valid while out_valid=1.
- out_result still wraps.

Structure
REQ-029 Package mac_dot_pkg SHALL hold the state enum, OP_W=16 and ACC_W=32.
REQ-030 SHALL instantiate the existing mac_16 (clk, reset, A, B, accumulator) as its single sub-module, with mac reset = reset || (state==CLEAR).

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- Basic: len=3, pairs (2,3),(7,3),(3,6) back-to-back -> out_valid 1 cycle after 3rd beat, out_result=45.
- Bubbles: same pairs with in_valid low 2 cycles between beats -> out_result=45, no change during bubbles.
- Large operands: len=2, (32091,11232),(2,8) -> out_result=360446128; len=0 -> out_result=0.
- Backpressure: out_ready low 3 cycles in DONE -> out_result stable; a start pulse there is ignored.
- Reset mid-run: reset after 1 of 3 beats -> IDLE, no out_valid; then len=1,(13,4) -> 52.
- MAC_DOT_CTRL_OVF_EN: len=2, (65535,65535) twice -> out_result=4294705154, ovf=1; next run ovf=0.

Source files
------------

// File: rtl/mac_dot_pkg.sv
// Shared types and widths for the dot-product MAC controller.
package mac_dot_pkg;

    localparam int OP_W  = 16;
    localparam int ACC_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_16.sv
// 16x16 unsigned multiply-accumulate with synchronous clear.
// The accumulator wraps modulo 2^ACC_W.
module mac_16
    import mac_dot_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [ACC_W-1:0] accumulator
);

    // Clear on reset, otherwise add the current product every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            accumulator <= '0;
        end else begin
            accumulator <= accumulator + (ACC_W'(a) * ACC_W'(b));
        end
    end

endmodule

// File: rtl/mac_dot_ctrl.sv
// Dot-product controller around a single mac_16 instance.
// Sequence: IDLE -> CLEAR (1 cycle, clears MAC) -> ACCUM (len beats) -> DONE.
// Optional feature: define MAC_DOT_CTRL_OVF_EN to add the sticky ovf output.
module mac_dot_ctrl
    import mac_dot_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_result,
`ifdef MAC_DOT_CTRL_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count;
    logic             transfer;
    logic             mac_reset;
    logic [OP_W-1:0]  mac_a;
    logic [OP_W-1:0]  mac_b;
    logic [ACC_W-1:0] acc;

    assign transfer  = in_valid && in_ready;
    assign mac_reset = reset || (state == CLEAR);

    // Operands reach the MAC only on a transfer so the accumulator holds otherwise.
    assign mac_a = transfer ? in_a : '0;
    assign mac_b = transfer ? in_b : '0;

    assign out_result = (state == DONE) ? acc : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                state_next = (len_q != '0) ? ACCUM : DONE;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (transfer && ((count + LEN_W'(1)) == len_q)) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Length latch and beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q <= '0;
            count <= '0;
        end else begin
            if (state == IDLE && start) len_q <= len;
            if (state == CLEAR) begin
                count <= '0;
            end else if (transfer) begin
                count <= count + LEN_W'(1);
            end
        end
    end

`ifdef MAC_DOT_CTRL_OVF_EN
    logic [ACC_W:0] sum_ext;
    assign sum_ext = {1'b0, acc} + {1'b0, ACC_W'(mac_a) * ACC_W'(mac_b)};

    // Sticky carry-out of the accumulation; cleared at the start of each run.
    always_ff @(posedge clk) begin
        if (mac_reset) begin
            ovf <= 1'b0;
        end else if (transfer && sum_ext[ACC_W]) begin
            ovf <= 1'b1;
        end
    end
`endif

    mac_16 u_mac (
        .clk         (clk),
        .reset       (mac_reset),
        .a           (mac_a),
        .b           (mac_b),
        .accumulator (acc)
    );

endmodule
